// File: rtl/output_serializer.sv
// Latches a packed vector of signed elements and streams them one per beat over a
// valid/ready handshake, tracking the running argmax of the accepted elements.
//
// state  | meaning
// IDLE   | waiting for capture
// STREAM | presenting elements, one beat per accepted handshake
// DONE   | one-cycle completion; argmax outputs are final
module output_serializer #(
  parameter int DATA_W    = 64,
  parameter int NUM_ELEMS = 6,
  parameter int IDX_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          capture,
  input  logic [DATA_W*NUM_ELEMS-1:0]   data_in,
  input  logic [IDX_W-1:0]              num_valid,
  output logic signed [DATA_W-1:0]      out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [IDX_W-1:0]              out_index,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_W-1:0]              argmax_idx,
  output logic signed [DATA_W-1:0]      argmax_val,
  output logic                          overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(NUM_ELEMS);

  state_t                        state_q, state_d;
  logic [DATA_W*NUM_ELEMS-1:0]   vec_q, vec_d;
  logic [IDX_W-1:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [IDX_W-1:0]              amax_idx_q, amax_idx_d;
  logic signed [DATA_W-1:0]      amax_val_q, amax_val_d;
  logic                          overrun_q, overrun_d;

  logic [IDX_W-1:0]              eff_cnt;
  logic signed [DATA_W-1:0]      cur_elem;
  logic                          is_last;
  logic                          accept;

  assign eff_cnt = (num_valid > MAX_CNT) ? MAX_CNT : num_valid;
  assign is_last = (idx_q == (cnt_q - IDX_W'(1)));
  assign accept  = (state_q == S_STREAM) && out_ready;

  // Element mux; indices at or beyond NUM_ELEMS never occur in STREAM.
  always_comb begin
    cur_elem = '0;
    for (int k = 0; k < NUM_ELEMS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_elem = vec_q[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    amax_idx_d = amax_idx_q;
    amax_val_d = amax_val_q;
    overrun_d  = capture && (state_q == S_STREAM);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (capture) begin
          vec_d      = data_in;
          cnt_d      = eff_cnt;
          idx_d      = '0;
          amax_idx_d = '0;
          amax_val_d = '0;
          state_d    = (eff_cnt == '0) ? S_DONE : S_STREAM;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_STREAM: begin
        if (accept) begin
          // Strict greater-than keeps the lower index on a tie.
          if ((idx_q == '0) || (cur_elem > amax_val_q)) begin
            amax_idx_d = idx_q;
            amax_val_d = cur_elem;
          end
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      amax_idx_q <= '0;
      amax_val_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      amax_idx_q <= amax_idx_d;
      amax_val_q <= amax_val_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_valid  = (state_q == S_STREAM);
  assign out_data   = cur_elem;
  assign out_index  = idx_q;
  assign out_last   = out_valid && is_last;
  assign busy       = (state_q == S_STREAM);
  assign done       = (state_q == S_DONE);
  assign argmax_idx = amax_idx_q;
  assign argmax_val = amax_val_q;
  assign overrun    = overrun_q;

endmodule
